// File: rtl/cache_line_refill.sv
// cache_line_refill: miss-driven refill engine in front of the cache data bank.
// It fetches one 8-beat line over a single read burst, writes the whole line
// to the bank in one cycle, and forwards the missed word to the CPU.
// Optional build macro: REFILL_EARLY_FWD_EN
//   defined   -> missed word is forwarded (registered) the cycle after its beat
//   undefined -> missed word is forwarded in the line-write cycle
module cache_line_refill #(
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 32,
   parameter int PADDR_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    miss_valid,
   output logic                    miss_ready,
   input  logic [PADDR_WIDTH-1:0]  miss_paddr,
   output logic                    rd_req,
   output logic [PADDR_WIDTH-1:0]  rd_addr,
   input  logic                    rd_req_ack,
   input  logic                    rd_data_valid,
   input  logic [DATA_WIDTH-1:0]   rd_data,
   input  logic                    rd_last,
   output logic                    bank_we,
   output logic                    bank_hit_write,
   output logic [ADDR_WIDTH-1:0]   bank_waddr,
   output logic [8*DATA_WIDTH-1:0] bank_din_all,
   output logic                    fwd_valid,
   output logic [DATA_WIDTH-1:0]   fwd_data,
   output logic                    done,
   output logic                    proto_err
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RECV = 2'd2, WRITE = 2'd3} state_t;

   state_t                       state;
   state_t                       state_nxt;
   logic [PADDR_WIDTH-6:0]       line_addr_q;
   logic [2:0]                   word_idx_q;
   logic [2:0]                   cnt;
   logic [7:0][DATA_WIDTH-1:0]   line_q;
   logic                         accept;
   logic                         beat_vld_p0;
   logic                         proto_err_p1;
   logic                         unused_paddr_lsb;

   // Byte offset inside a word has no meaning for a line refill.
   assign unused_paddr_lsb = ^miss_paddr[1:0];

   assign accept      = (state == IDLE) && miss_valid;
   assign beat_vld_p0 = (state == RECV) && rd_data_valid;

   assign rd_addr        = {line_addr_q, 5'b00000};
   assign bank_waddr     = {line_addr_q[ADDR_WIDTH-4:0], 3'b000};
   assign bank_din_all   = line_q;
   assign bank_hit_write = bank_we;
   assign proto_err      = proto_err_p1;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Miss address latch, beat counter, line assembly and rd_last checking.
   always_ff @(posedge clk) begin
      if (rst) begin
         line_addr_q  <= '0;
         word_idx_q   <= '0;
         cnt          <= '0;
         line_q       <= '0;
         proto_err_p1 <= 1'b0;
      end else begin
         // rd_last must coincide exactly with the eighth beat
         proto_err_p1 <= beat_vld_p0 && (rd_last != (cnt == 3'd7));
         if (accept) begin
            line_addr_q <= miss_paddr[PADDR_WIDTH-1:5];
            word_idx_q  <= miss_paddr[4:2];
            cnt         <= 3'd0;
         end
         if (beat_vld_p0) begin
            line_q[cnt] <= rd_data;
            cnt         <= cnt + 3'd1;
         end
      end
   end

`ifdef REFILL_EARLY_FWD_EN
   logic                  fwd_vld_p1;
   logic [DATA_WIDTH-1:0] fwd_data_p1;

   // Capture the missed word as its beat arrives and present it next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         fwd_vld_p1  <= 1'b0;
         fwd_data_p1 <= '0;
      end else begin
         fwd_vld_p1 <= beat_vld_p0 && (cnt == word_idx_q);
         if (beat_vld_p0 && (cnt == word_idx_q)) fwd_data_p1 <= rd_data;
      end
   end

   assign fwd_valid = fwd_vld_p1;
   assign fwd_data  = fwd_data_p1;
`else
   assign fwd_valid = (state == WRITE);
   assign fwd_data  = line_q[word_idx_q];
`endif

   // Next-state and handshake outputs; transitions depend on the beat count only.
   always_comb begin
      state_nxt  = state;
      miss_ready = 1'b0;
      rd_req     = 1'b0;
      bank_we    = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            miss_ready = 1'b1;
            if (miss_valid) state_nxt = REQ;
         end
         REQ: begin
            rd_req = 1'b1;
            if (rd_req_ack) state_nxt = RECV;
         end
         RECV: begin
            if (beat_vld_p0 && (cnt == 3'd7)) state_nxt = WRITE;
         end
         WRITE: begin
            bank_we   = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache_line_refill.sv
// tb_cache_line_refill: scoreboard bench for cache_line_refill.
// The driver issues misses and bursts and queues the expected line writes,
// forwarded words and protocol-error pulses; a negedge monitor checks them.
module tb_cache_line_refill;

   logic         clk = 1'b0;
   logic         rst;
   logic         miss_valid;
   logic         miss_ready;
   logic [31:0]  miss_paddr;
   logic         rd_req;
   logic [31:0]  rd_addr;
   logic         rd_req_ack;
   logic         rd_data_valid;
   logic [31:0]  rd_data;
   logic         rd_last;
   logic         bank_we;
   logic         bank_hit_write;
   logic [9:0]   bank_waddr;
   logic [255:0] bank_din_all;
   logic         fwd_valid;
   logic [31:0]  fwd_data;
   logic         done;
   logic         proto_err;

   cache_line_refill #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .PADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_paddr(miss_paddr),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_req_ack(rd_req_ack),
      .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_last(rd_last),
      .bank_we(bank_we), .bank_hit_write(bank_hit_write), .bank_waddr(bank_waddr),
      .bank_din_all(bank_din_all), .fwd_valid(fwd_valid), .fwd_data(fwd_data),
      .done(done), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int c; logic [9:0] a; logic [255:0] l; } wr_t;
   typedef struct { int c; logic [31:0] d; } fw_t;

   wr_t         wq[$];
   fw_t         fq[$];
   int          pq[$];
   logic [31:0] exp_rd_addr = 32'h0;
   int          last_wr_cyc = -100;
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_miss_ready"}, miss_ready, 1);
      chk({tag, "_rd_req"}, rd_req, 0);
      chk({tag, "_bank_we"}, bank_we, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_fwd_valid"}, fwd_valid, 0);
      chk({tag, "_proto_err"}, proto_err, 0);
   endtask

   // Monitor: compare DUT activity against the queued expectations.
   always @(negedge clk) begin
      if (!rst) begin
         if (bank_we) begin
            if (wq.size() == 0) chk("unexpected_bank_we", 1, 0);
            else begin
               wr_t w;
               w = wq.pop_front();
               chk("write_cycle", cyc, w.c);
               chk("bank_waddr", bank_waddr, w.a);
               chk("bank_din_all", bank_din_all, w.l);
               chk("done_with_we", done, 1);
               chk("hit_write_with_we", bank_hit_write, 1);
               chk("miss_ready_in_write", miss_ready, 0);
            end
         end else begin
            chk("done_hitwr_without_we", {done, bank_hit_write}, 0);
         end
         if (fwd_valid) begin
            if (fq.size() == 0) chk("unexpected_fwd_valid", 1, 0);
            else begin
               fw_t f;
               f = fq.pop_front();
               chk("fwd_cycle", cyc, f.c);
               chk("fwd_data", fwd_data, f.d);
            end
         end
         if (proto_err) begin
            if (pq.size() == 0) chk("unexpected_proto_err", 1, 0);
            else begin
               int pc;
               pc = pq.pop_front();
               chk("proto_err_cycle", cyc, pc);
            end
         end
         if (rd_req) begin
            chk("rd_addr", rd_addr, exp_rd_addr);
            chk("miss_ready_in_req", miss_ready, 0);
         end
      end
   end

   // One miss: accept, request (with optional ack delay), 8 beats, write.
   // bad_last: 0 correct, 1 rd_last also on beat 5, 2 rd_last missing on beat 7.
   task automatic run_miss(input logic [31:0] pa, input int ack_dly, input bit gap,
                           input int bad_last, input int rst_after, input bit hold,
                           input bit b2b, input bit seq, input logic [31:0] base);
      logic [31:0]  d[8];
      logic [255:0] ln;
      logic [31:0]  wa;
      int           idx;
      int           n;
      wr_t          w;
      fw_t          f;
      idx = int'(pa[4:2]);
      ln  = '0;
      for (int i = 0; i < 8; i++) begin
         d[i] = seq ? base + i : $urandom;
         ln[i*32 +: 32] = d[i];
      end
      wa = (pa >> 2) & 32'h0000_03F8;

      miss_valid = 1'b1;
      miss_paddr = pa;
      n = 0;
      while (!miss_ready) begin
         @(posedge clk); #1;
         rd_data_valid = 1'b0;
         n++;
         if (n > 50) begin
            chk("timeout_miss_ready", 0, 1);
            return;
         end
      end
      rd_data_valid = 1'b0;
      if (b2b) chk("b2b_accept_cycle", cyc, last_wr_cyc + 1);
      exp_rd_addr = pa & 32'hFFFF_FFE0;

      @(posedge clk); #1;
      miss_valid = hold;
      miss_paddr = $urandom;
      chk("rd_req_after_accept", rd_req, 1);
      rd_data_valid = 1'b1;
      rd_data       = $urandom;
      rd_last       = 1'b1;
      for (int k = 0; k < ack_dly; k++) begin
         @(posedge clk); #1;
         rd_data_valid = 1'b0;
         chk("rd_req_held", rd_req, 1);
      end
      rd_req_ack = 1'b1;
      @(posedge clk); #1;
      rd_req_ack    = 1'b0;
      rd_data_valid = 1'b0;
      rd_last       = 1'b0;

      for (int i = 0; i < 8; i++) begin
         if (gap && i > 0) begin
            rd_data_valid = 1'b0;
            rd_data       = $urandom;
            rd_last       = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
         rd_data_valid = 1'b1;
         rd_data       = d[i];
         rd_last       = (i == 7) || (bad_last == 1 && i == 5);
         if (bad_last == 2 && i == 7) rd_last = 1'b0;
         if ((bad_last == 1 && i == 5) || (bad_last == 2 && i == 7)) pq.push_back(cyc + 1);
`ifdef REFILL_EARLY_FWD_EN
         if (i == idx) begin
            f.c = cyc + 1; f.d = d[i]; fq.push_back(f);
         end
`endif
         if (i == 7) begin
            w.c = cyc + 1; w.a = wa[9:0]; w.l = ln; wq.push_back(w);
`ifndef REFILL_EARLY_FWD_EN
            f.c = cyc + 1; f.d = d[idx]; fq.push_back(f);
`endif
         end
         @(posedge clk); #1;
         if (i == rst_after) begin
            rd_data_valid = 1'b0;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check_idle("after_mid_reset");
            return;
         end
      end
      // WRITE cycle: a stray beat here must be ignored
      last_wr_cyc   = cyc;
      rd_data_valid = 1'b1;
      rd_data       = $urandom;
      rd_last       = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit prev_hold;
      bit h;
      rst = 1'b1; miss_valid = 1'b0; miss_paddr = 32'h0; rd_req_ack = 1'b0;
      rd_data_valid = 1'b0; rd_data = 32'h0; rd_last = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");
      chk("reset_bank_din_all", bank_din_all, 0);
      chk("reset_rd_addr", rd_addr, 0);
      chk("reset_bank_waddr", bank_waddr, 0);
      chk("reset_fwd_data", fwd_data, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check_idle("idle");

      // basic refill
      run_miss(32'h0000_1A64, 0, 0, 0, -1, 0, 0, 1, 32'hA0);
      // forwarding of word 3
      run_miss(32'h0000_0A2C, 0, 0, 0, -1, 0, 0, 1, 32'hB0);
      // backpressure: delayed ack, gapped beats
      run_miss(32'h1234_5678, 5, 1, 0, -1, 0, 0, 0, 0);
      // protocol errors
      run_miss(32'h0000_3F40, 1, 0, 1, -1, 0, 0, 0, 0);
      run_miss(32'hFFFF_FFFC, 0, 1, 2, -1, 0, 0, 0, 0);
      // reset after beat 4, then a normal miss
      run_miss(32'h0000_0118, 0, 0, 0, 4, 0, 0, 0, 0);
      run_miss(32'h0000_0204, 2, 0, 0, -1, 0, 0, 1, 32'hC0);
      // back-to-back with miss_valid held high
      run_miss(32'h0000_1000, 0, 0, 0, -1, 1, 0, 0, 0);
      run_miss(32'h0000_2014, 0, 0, 0, -1, 1, 1, 0, 0);
      run_miss(32'h0000_301C, 1, 0, 0, -1, 0, 1, 0, 0);

      // randomized misses
      prev_hold = 1'b0;
      for (int t = 0; t < 25; t++) begin
         h = (t == 24) ? 1'b0 : 1'($urandom_range(0, 1));
         run_miss($urandom, $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                  -1, h, prev_hold, 0, 0);
         prev_hold = h;
      end

      miss_valid = 1'b0;
      @(posedge clk); #1;
      rd_data_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check_idle("final");
      chk("pending_writes", wq.size(), 0);
      chk("pending_fwds", fq.size(), 0);
      chk("pending_proto_errs", pq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cache_line_refill.md
Name: cache_line_refill

Overview:
- Refill stage directly upstream of the cache data bank.
- On a cache miss it issues one 8-beat read burst to the memory interface and assembles the 32-bit beats into a 256-bit line.
- It then writes the whole line into the bank in a single hit_write cycle.
- It also returns the missed word to the CPU pipeline, so the stalled load can resume.

Parameters:
- ADDR_WIDTH, 10, width of the bank word address (bank_waddr); bank line index = bank_waddr[ADDR_WIDTH-1:3].
- DATA_WIDTH, 32, beat/word width; line = 8*DATA_WIDTH bits.
- PADDR_WIDTH, 32, physical byte-address width.

Ports:
- clk, input, 1, single clock; all logic on posedge.
- rst, input, 1, synchronous, active-high reset.
- miss_valid, input, 1, miss request valid.
- miss_ready, output, 1, high only in IDLE; request accepted when miss_valid & miss_ready.
- miss_paddr, input, PADDR_WIDTH, byte address of missed access.
- rd_req, output, 1, burst request to memory interface; held until acknowledged.
- rd_addr, output, PADDR_WIDTH, line-aligned burst address {paddr[PADDR_WIDTH-1:5],5'b0}.
- rd_req_ack, input, 1, memory accepts request (rd_req & rd_req_ack).
- rd_data_valid, input, 1, one beat present.
- rd_data, input, DATA_WIDTH, beat data, incremental order word 0..7.
- rd_last, input, 1, final beat marker.
- bank_we, output, 1, bank write enable (all 32 byte lanes).
- bank_hit_write, output, 1, refill-write select to bank; equals bank_we.
- bank_waddr, output, ADDR_WIDTH, {paddr[ADDR_WIDTH+1:5],3'b000}.
- bank_din_all, output, 8*DATA_WIDTH, assembled line; word i at bits [32i+31:32i].
- fwd_valid, output, 1, one-cycle pulse: missed word available.
- fwd_data, output, DATA_WIDTH, missed word (word index paddr[4:2]).
- done, output, 1, one-cycle pulse in the line-write cycle.
- proto_err, output, 1, one-cycle pulse on rd_last/beat-count mismatch.

Behaviour:
- Reset: state=IDLE, beat counter=0, line buffer=0, latched address=0. All outputs 0 except miss_ready=1.
- IDLE: miss_ready=1. On accept, latch miss_paddr and clear the counter -> REQ.
- REQ: rd_req=1, rd_addr stable. Stay until rd_req_ack; on ack -> RECV. Beats are not captured in REQ.
- RECV: each rd_data_valid writes rd_data into line[cnt], then cnt++ (3-bit).
  - Beat with cnt==7 -> WRITE; cnt wraps to 0.
  - rd_last is checked, not trusted. rd_last=1 with cnt!=7, or rd_last=0 with cnt==7, pulses proto_err the next cycle. The transition is still governed by cnt only.
- WRITE (exactly one cycle): bank_we=bank_hit_write=1, done=1, bank_waddr from latched address, bank_din_all = full line -> IDLE.
- Latency:
  - Accept at T -> rd_req high from T+1.
  - Last beat at B -> bank write at B+1 -> miss_ready=1 at B+2.
  - Minimum miss-to-write is 10 cycles: ack at T+1, beats T+2..T+9, write T+10.
- bank_din_all is driven from the line register continuously. It is only meaningful while bank_we=1.
- bank_we is never high outside WRITE. fwd_valid pulses exactly once per miss.
- rd_data_valid in IDLE/REQ/WRITE is ignored.
- miss_valid outside IDLE is not accepted and has no effect.
- rst in any state returns to IDLE next cycle. A pending burst is abandoned, with no bank write and no fwd/done pulse.

Optional Feature:
- REFILL_EARLY_FWD_EN defined:
  - fwd_valid pulses the cycle after the beat with cnt == latched paddr[4:2] is captured; fwd_data = that beat, registered.
  - Word 7 is therefore forwarded in the same cycle as WRITE.
- Undefined:
  - fwd_valid pulses in the WRITE cycle, coincident with done; fwd_data = line[paddr[4:2]].

Test Plan:
- Basic refill:
  - Stimulus: miss_paddr=0x0000_1A64; ack on first rd_req cycle; beats 0xA0..0xA7, zero gaps.
  - Required: rd_addr=0x0000_1A60; bank_waddr=0x298; bank_din_all={0xA7,...,0xA0}; bank_we/done exactly one cycle at B+1.
- Forwarding (paddr[4:2]=3, beats 0xB0..0xB7):
  - fwd_data=0xB3, single pulse.
  - Pulse one cycle after beat 3 with REFILL_EARLY_FWD_EN; in the WRITE cycle without it.
- Backpressure:
  - Stimulus: rd_req_ack delayed 5 cycles; rd_data_valid low on alternate cycles.
  - Required: rd_req held with constant rd_addr; line still correct; no early bank_we; miss_ready=0 throughout.
- Protocol error:
  - Stimulus: rd_last=1 on beat 5, or rd_last=0 on beat 7.
  - Required: proto_err pulses once; write still occurs after 8th beat.
- Reset mid-burst:
  - Stimulus: rst after beat 4.
  - Required: IDLE, miss_ready=1 next cycle; no bank_we/done/fwd_valid. A following miss refills correctly.
- Back-to-back misses:
  - Stimulus: miss_valid held high.
  - Required: second miss accepted at B+2; stray rd_data_valid during WRITE ignored.
